// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the tick interval timer.
//   state_t          : controller state encoding (IDLE, COUNT, DONE)
//   DEFAULT_LIMIT_16 : 16-bit limit loaded at reset
package tick_timer_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [15:0] DEFAULT_LIMIT_16 = 16'h66C7;

endpackage : tick_timer_pkg

// File: rtl/tick_interval_timer_sync.sv
// Tick qualifier for the interval timer.
// SYNC=1: 2-FF synchroniser followed by an edge flop. tick_q is high for
//         exactly one cycle per rising edge of tick. It is high in the cycle
//         after the second synchroniser edge, so a counter that samples tick_q
//         updates 3 clk after the tick edge.
// SYNC=0: tick is already a synchronous one-cycle strobe and passes straight through.
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   tick   in  raw tick source
//   tick_q out qualified one-cycle tick
module tick_sync #(
    parameter bit SYNC = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    output logic tick_q
);

    generate
        if (SYNC) begin : g_sync
            localparam int unsigned STAGES = 3;

            // [0],[1] synchroniser, [2] previous synchronised level for edge detect
            logic [STAGES-1:0] sh_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sh_q <= '0;
                end else begin
                    sh_q <= {sh_q[STAGES-2:0], tick};
                end
            end

            assign tick_q = sh_q[1] & ~sh_q[2];
        end else begin : g_bypass
            assign tick_q = tick;
        end
    endgenerate

endmodule : tick_sync

// File: rtl/tick_interval_timer.sv
// Tick interval timer: counts qualified ticks up to a programmable limit and
// flags expiry, in one-shot or periodic (auto-reload) mode, with a saturating
// count of completed periods.
// Ports:
//   clk       in  system clock
//   rst_n     in  synchronous active-low reset
//   tick      in  count event source
//   run       in  level enable; low stops and clears the timer
//   mode      in  0 = one-shot, 1 = periodic (captured on IDLE->COUNT)
//   limit_we  in  limit write strobe (honoured in IDLE only)
//   limit_in  in  new limit (0 behaves as 1)
//   reached   out registered expiry flag
//   expire    out one-cycle expiry pulse
//   count     out current tick count
//   periods   out completed periods, saturating
//   busy      out high while counting
module tick_interval_timer
    import tick_timer_pkg::*;
#(
    parameter int unsigned       WIDTH         = 16,
    parameter logic [WIDTH-1:0]  DEFAULT_LIMIT = WIDTH'(DEFAULT_LIMIT_16),
    parameter int unsigned       PWIDTH        = 8,
    parameter bit                SYNC          = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              run,
    input  logic              mode,
    input  logic              limit_we,
    input  logic [WIDTH-1:0]  limit_in,
    output logic              reached,
    output logic              expire,
    output logic [WIDTH-1:0]  count,
    output logic [PWIDTH-1:0] periods,
    output logic              busy
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   limit_q, limit_d;
    logic [PWIDTH-1:0]  periods_q, periods_d;
    logic               reached_q, reached_d;
    logic               expire_q, expire_d;
    logic               busy_q, busy_d;
    logic               mode_q, mode_d;

    logic               tick_q;
    logic [WIDTH-1:0]   eff_limit;
    logic [WIDTH-1:0]   count_inc;
    logic [PWIDTH-1:0]  periods_inc;

    // Tick qualification
    tick_sync #(
        .SYNC (SYNC)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .tick_q (tick_q)
    );

    // A zero limit would never be reached by an incrementing count
    assign eff_limit   = (limit_q == '0) ? WIDTH'(1) : limit_q;
    assign count_inc   = count_q + WIDTH'(1);
    assign periods_inc = (periods_q == '1) ? periods_q : periods_q + PWIDTH'(1);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            limit_q   <= DEFAULT_LIMIT;
            periods_q <= '0;
            reached_q <= 1'b0;
            expire_q  <= 1'b0;
            busy_q    <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            periods_q <= periods_d;
            reached_q <= reached_d;
            expire_q  <= expire_d;
            busy_q    <= busy_d;
            mode_q    <= mode_d;
        end
    end

    // Next-state and next-output logic; run low takes precedence over expiry
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        periods_d = periods_q;
        reached_d = 1'b0;
        expire_d  = 1'b0;
        mode_d    = mode_q;

        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (limit_we) begin
                    limit_d = limit_in;
                end
                // Tick in the start cycle is deliberately not counted
                if (run) begin
                    state_d   = COUNT;
                    mode_d    = mode;
                    periods_d = '0;
                end
            end

            COUNT: begin
                if (!run) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (tick_q) begin
                    if (count_inc == eff_limit) begin
                        expire_d  = 1'b1;
                        reached_d = 1'b1;
                        periods_d = periods_inc;
                        if (mode_q) begin
                            count_d = '0;
                        end else begin
                            state_d = DONE;
                            count_d = eff_limit;
                        end
                    end else begin
                        count_d = count_inc;
                    end
                end
            end

            DONE: begin
                if (!run) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    reached_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        busy_d = (state_d == COUNT);
    end

    assign reached = reached_q;
    assign expire  = expire_q;
    assign count   = count_q;
    assign periods = periods_q;
    assign busy    = busy_q;

endmodule : tick_interval_timer
